// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// pwm_capture_pkg : shared FSM encoding and default sizing for pwm_capture
// Rev 1.0
// ============================================================================
package pwm_capture_pkg;

  localparam int unsigned           CNT_W_DEF       = 20;
  localparam logic [CNT_W_DEF-1:0]  TIMEOUT_CYC_DEF = 20'd1000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pwm_in_conditioner.sv
`default_nettype none
// ============================================================================
// pwm_in_conditioner : 2-FF synchronizer, optional glitch filter
// (PWM_CAPTURE_GLITCH_FILTER_EN) and rise/fall edge detect. Rev 1.0
// ============================================================================
module pwm_in_conditioner
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
#(
  parameter int unsigned FILT_LEN = 4
)
`endif
(
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       lvl_prev_q;
  logic       w_level;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_i};
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] filt_cnt_q;
  logic          filt_q;

  // The accepted level flips only after FILT_LEN consecutive disagreeing samples,
  // so both edges are delayed by the same FILT_LEN cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      filt_cnt_q <= '0;
      filt_q     <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
      filt_cnt_q <= '0;
      filt_q     <= sync_q[1];
    end else begin
      filt_cnt_q <= filt_cnt_q + FW'(1);
    end
  end

  assign w_level = filt_q;
`else
  assign w_level = sync_q[1];
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lvl_prev_q <= 1'b0;
    end else begin
      lvl_prev_q <= w_level;
    end
  end

  assign level_o = w_level;
  assign rise_o  = w_level & ~lvl_prev_q;
  assign fall_o  = ~w_level & lvl_prev_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// pwm_capture : measures PWM high time / period and flags a stuck line.
// Optional glitch filter: PWM_CAPTURE_GLITCH_FILTER_EN. Rev 1.0
// ============================================================================
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned       CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0]  TIMEOUT_CYC = TIMEOUT_CYC_DEF
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  ,
  parameter int unsigned       FILT_LEN    = 4
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic w_level;
  logic w_rise;
  logic w_fall;

  pwm_in_conditioner
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
    u_cond (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pwm_i     (pwm_in),
      .level_o   (w_level),
      .rise_o    (w_rise),
      .fall_o    (w_fall)
    );

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] high_lat_q,   high_lat_d;
  logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             valid_q,      valid_d;
  logic             stuck_q,      stuck_d;
  logic             stuck_lvl_q,  stuck_lvl_d;
  logic             w_timeout;
  logic             timeout_hit;

  assign w_timeout = (cnt_q == TIMEOUT_CYC);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      high_lat_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      stuck_lvl_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_lat_q   <= high_lat_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      stuck_lvl_q  <= stuck_lvl_d;
    end
  end

  // Edges are tested before the timeout so an edge landing on the limit wins.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_ONE;
    high_lat_d   = high_lat_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    stuck_d      = stuck_q;
    stuck_lvl_d  = stuck_lvl_q;
    timeout_hit  = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      stuck_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = '0;
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (w_rise) begin
            cnt_d   = CNT_ONE;
            state_d = ST_HIGH;
          end else if (w_timeout) begin
            timeout_hit = 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            high_lat_d = cnt_q;
            state_d    = ST_LOW;
          end else if (w_timeout) begin
            timeout_hit = 1'b1;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            high_cnt_d   = high_lat_q;
            period_cnt_d = cnt_q;
            valid_d      = 1'b1;
            stuck_d      = 1'b0;
            cnt_d        = CNT_ONE;
            state_d      = ST_HIGH;
          end else if (w_timeout) begin
            timeout_hit = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (timeout_hit) begin
        stuck_d      = 1'b1;
        stuck_lvl_d  = w_level;
        high_cnt_d   = '0;
        period_cnt_d = '0;
        cnt_d        = '0;
        state_d      = ST_SYNC;
      end
    end
  end

  assign high_cnt    = high_cnt_q;
  assign period_cnt  = period_cnt_q;
  assign meas_valid  = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_lvl_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// tb_pwm_capture : directed, scoreboard-checked bench for pwm_capture. Rev 1.0
// ============================================================================
module tb_pwm_capture;

  localparam int unsigned CNT_W = 20;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam logic GLITCH_MODEL_LVL = 1'b1;
`else
  localparam logic GLITCH_MODEL_LVL = 1'b0;
`endif

  logic             sys_clk;
  logic             sys_rst_n;
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  pwm_capture #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (20'd500)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .en          (en),
    .pwm_in      (pwm_in),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int h;
    int p;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: level the DUT should see, and whether a rise has
  // already opened a period that the DUT will measure.
  logic cur_lvl;
  bit   track;
  int   since_rise;
  int   hi_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // v is driven on the pin; mv is the level the DUT is expected to act on.
  task automatic drive(input logic v, input logic mv, input int n);
    exp_t e;
    if (mv && !cur_lvl) begin
      if (track) begin
        e.h = hi_len;
        e.p = since_rise;
        exp_q.push_back(e);
      end
      track      = 1'b1;
      since_rise = 0;
      hi_len     = 0;
    end
    cur_lvl = mv;
    pwm_in  = v;
    repeat (n) begin
      @(negedge sys_clk);
      since_rise++;
      if (mv) hi_len++;
    end
  endtask

  task automatic drive_level(input logic v, input int n);
    drive(v, v, n);
  endtask

  task automatic period(input int h, input int p);
    drive_level(1'b1, h);
    drive_level(1'b0, p - h);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_cnt"},    high_cnt,    32'd0);
    check({tag, "_period_cnt"},  period_cnt,  32'd0);
    check({tag, "_meas_valid"},  meas_valid,  32'd0);
    check({tag, "_stuck"},       stuck,       32'd0);
    check({tag, "_stuck_level"}, stuck_level, 32'd0);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (meas_valid === 1'b1) begin
        check("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("high_cnt",      high_cnt,   e.h);
          check("period_cnt",    period_cnt, e.p);
          check("stuck_on_valid", stuck,     32'd0);
        end
      end
    end
  end

  initial begin : stim
    sys_rst_n  = 1'b0;
    en         = 1'b0;
    pwm_in     = 1'b0;
    cur_lvl    = 1'b0;
    track      = 1'b0;
    since_rise = 0;
    hi_len     = 0;

    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Steady H=30 / P=100
    en = 1'b1;
    drive_level(1'b0, 10);
    repeat (4) period(30, 100);
    check("steady_stuck", stuck, 32'd0);

    // Asynchronous reset in the middle of a high phase, released while low
    drive_level(1'b1, 15);
    #3 sys_rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    track = 1'b0;
    drive_level(1'b1, 14);
    drive_level(1'b0, 10);
    sys_rst_n = 1'b1;
    drive_level(1'b0, 60);
    repeat (2) period(30, 100);

    // Line stuck high after a rise
    drive_level(1'b1, 495);
    check("stuck_before_limit", stuck, 32'd0);
    drive_level(1'b1, 105);
    check("stuck_set",         stuck,       32'd1);
    check("stuck_level",       stuck_level, 32'd1);
    check("stuck_high_cnt",    high_cnt,    32'd0);
    check("stuck_period_cnt",  period_cnt,  32'd0);
    track = 1'b0;
    drive_level(1'b0, 10);
    repeat (3) period(10, 20);
    check("stuck_cleared", stuck, 32'd0);

    // Enable dropped during a low phase
    repeat (2) period(30, 100);
    drive_level(1'b1, 30);
    drive_level(1'b0, 20);
    en    = 1'b0;
    track = 1'b0;
    drive_level(1'b0, 10);
    check("idle_high_hold",   high_cnt,   32'd30);
    check("idle_period_hold", period_cnt, 32'd100);
    check("idle_no_valid",    meas_valid, 32'd0);
    check("idle_stuck",       stuck,      32'd0);
    drive_level(1'b0, 40);
    en = 1'b1;
    drive_level(1'b0, 20);
    repeat (2) period(25, 80);

`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    // Fastest waveform: toggle every cycle
    repeat (8) period(1, 2);
`endif

    // Two-cycle low glitch inside a 40-cycle high phase
    period(40, 100);
    drive(1'b1, 1'b1, 15);
    drive(1'b0, GLITCH_MODEL_LVL, 2);
    drive(1'b1, 1'b1, 23);
    drive(1'b0, 1'b0, 60);
    period(40, 100);
    drive_level(1'b1, 5);
    drive_level(1'b0, 20);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
